logic_gates_checker: RTL and testbench

- Self-checking sequencer that sits around the logic_gates block.
- Upstream role: drives the block's A/B inputs through every input combination, optionally over several passes.
- Downstream role: samples the seven gate outputs after a programmable settle delay and compares them with golden values.
- Reports an error count, the first failing vector, which gates failed on it, and pass/done status. Used for on-target bring-up and for the self-checking benches.

---
 rtl/logic_gates_checker.sv | 134 +++++++++++++
 tb/tb_logic_gates_checker.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gates_checker.sv
// Self-checking sequencer for the logic_gates block: sweeps every {A,B} vector,
// waits a settle delay, compares the seven gate outputs with golden values and reports.
module logic_gates_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             A,
  output logic             B,
  input  logic             and_Y,
  input  logic             nand_Y,
  input  logic             or_Y,
  input  logic             nor_Y,
  input  logic             xor_Y,
  input  logic             xnor_Y,
  input  logic             not_Y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_vec,
  output logic [6:0]       first_fail_mask
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]       PASS_LAST   = 8'(NUM_PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  state_t           state;
  logic [1:0]       vec;
  logic [7:0]       pass_idx;
  logic [7:0]       settle_cnt;
  logic [6:0]       golden;
  logic [6:0]       observed;
  logic [6:0]       mask;
  logic [1:0]       vec_inc;
  logic [ERR_W-1:0] err_next;

  // Golden values come from the registered stimulus, so they line up with what the DUT sees.
  always_comb begin
    golden   = {~A, ~(A ^ B), A ^ B, ~(A | B), A | B, ~(A & B), A & B};
    observed = {not_Y, xnor_Y, xor_Y, nor_Y, or_Y, nand_Y, and_Y};
    mask     = golden ^ observed;
    vec_inc  = vec + 2'd1;
    err_next = err_count;
    if (mask != 7'd0 && err_count != ERR_MAX) begin
      err_next = err_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      vec              <= 2'd0;
      pass_idx         <= 8'd0;
      settle_cnt       <= 8'd0;
      A                <= 1'b0;
      B                <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= 2'd0;
      first_fail_mask  <= 7'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= SETTLE;
            vec              <= 2'd0;
            pass_idx         <= 8'd0;
            settle_cnt       <= 8'd0;
            A                <= 1'b0;
            B                <= 1'b0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= 2'd0;
            first_fail_mask  <= 7'd0;
          end
        end

        SETTLE: begin
          settle_cnt <= settle_cnt + 8'd1;
          if (settle_cnt == SETTLE_LAST) begin
            state <= CHECK;
          end
        end

        // Error update and the advance to the next vector happen in the same cycle.
        CHECK: begin
          err_count  <= err_next;
          settle_cnt <= 8'd0;
          if (mask != 7'd0 && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_vec   <= {A, B};
            first_fail_mask  <= mask;
          end
          if (vec == 2'd3) begin
            vec <= 2'd0;
            A   <= 1'b0;
            B   <= 1'b0;
            if (pass_idx == PASS_LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else begin
              state    <= SETTLE;
              pass_idx <= pass_idx + 8'd1;
            end
          end else begin
            state <= SETTLE;
            vec   <= vec_inc;
            A     <= vec_inc[1];
            B     <= vec_inc[0];
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_gates_checker.sv
// Bench for logic_gates_checker: three configurations driven by a faultable gate model,
// results compared against a vector-sweep reference model.
module tb_logic_gates_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_s  [3];
  logic       a_s      [3];
  logic       b_s      [3];
  logic [6:0] y_s      [3];
  logic       busy_s   [3];
  logic       done_s   [3];
  logic       pass_s   [3];
  logic       ffv_s    [3];
  logic [1:0] ffvec_s  [3];
  logic [6:0] ffmask_s [3];
  logic [7:0] err0;
  logic [7:0] err1;
  logic [1:0] err2;

  // Per instance, per gate: 0 healthy, 1 stuck at 0, 2 stuck at 1, 3 inverted.
  logic [1:0] fmode [3][7];

  int checks_total  = 0;
  int checks_passed = 0;

  function automatic logic ideal_gate(input int g, input logic a, input logic b);
    case (g)
      0:       return a & b;
      1:       return !(a && b);
      2:       return a | b;
      3:       return !(a || b);
      4:       return a != b;
      5:       return a == b;
      default: return !a;
    endcase
  endfunction

  function automatic logic faulty_gate(input int g, input logic a, input logic b,
                                       input logic [1:0] m);
    case (m)
      2'd0:    return ideal_gate(g, a, b);
      2'd1:    return 1'b0;
      2'd2:    return 1'b1;
      default: return !ideal_gate(g, a, b);
    endcase
  endfunction

  // The gates under test, with injectable faults.
  always_comb begin
    y_s = '{default: 7'd0};
    for (int k = 0; k < 3; k++) begin
      for (int g = 0; g < 7; g++) begin
        y_s[k][g] = faulty_gate(g, a_s[k], b_s[k], fmode[k][g]);
      end
    end
  end

  logic_gates_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(1), .ERR_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .A(a_s[0]), .B(b_s[0]),
    .and_Y(y_s[0][0]), .nand_Y(y_s[0][1]), .or_Y(y_s[0][2]), .nor_Y(y_s[0][3]),
    .xor_Y(y_s[0][4]), .xnor_Y(y_s[0][5]), .not_Y(y_s[0][6]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .err_count(err0),
    .first_fail_valid(ffv_s[0]), .first_fail_vec(ffvec_s[0]), .first_fail_mask(ffmask_s[0])
  );

  logic_gates_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(3), .ERR_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .A(a_s[1]), .B(b_s[1]),
    .and_Y(y_s[1][0]), .nand_Y(y_s[1][1]), .or_Y(y_s[1][2]), .nor_Y(y_s[1][3]),
    .xor_Y(y_s[1][4]), .xnor_Y(y_s[1][5]), .not_Y(y_s[1][6]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .err_count(err1),
    .first_fail_valid(ffv_s[1]), .first_fail_vec(ffvec_s[1]), .first_fail_mask(ffmask_s[1])
  );

  logic_gates_checker #(.SETTLE_CYCLES(1), .NUM_PASSES(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .A(a_s[2]), .B(b_s[2]),
    .and_Y(y_s[2][0]), .nand_Y(y_s[2][1]), .or_Y(y_s[2][2]), .nor_Y(y_s[2][3]),
    .xor_Y(y_s[2][4]), .xnor_Y(y_s[2][5]), .not_Y(y_s[2][6]),
    .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]), .err_count(err2),
    .first_fail_valid(ffv_s[2]), .first_fail_vec(ffvec_s[2]), .first_fail_mask(ffmask_s[2])
  );

  function automatic int settle_of(input int k);
    return (k == 2) ? 1 : 2;
  endfunction

  function automatic int passes_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
  endfunction

  function automatic int err_max_of(input int k);
    return (k == 2) ? 3 : 255;
  endfunction

  function automatic logic [7:0] err_of(input int k);
    if (k == 0) return err0;
    if (k == 1) return err1;
    return {6'd0, err2};
  endfunction

  // Reference: walk every pass and vector, count failing vectors, remember the first one.
  function automatic void model(input int k, output int err, output logic fvalid,
                                output logic [1:0] fvec, output logic [6:0] fmask);
    logic [6:0] m;
    logic a;
    logic b;
    err    = 0;
    fvalid = 1'b0;
    fvec   = 2'd0;
    fmask  = 7'd0;
    for (int p = 0; p < passes_of(k); p++) begin
      for (int v = 0; v < 4; v++) begin
        a = (v / 2) == 1;
        b = (v % 2) == 1;
        m = 7'd0;
        for (int g = 0; g < 7; g++) begin
          m[g] = faulty_gate(g, a, b, fmode[k][g]) != ideal_gate(g, a, b);
        end
        if (m != 7'd0) begin
          if (err < err_max_of(k)) err++;
          if (!fvalid) begin
            fvalid = 1'b1;
            fvec   = {a, b};
            fmask  = m;
          end
        end
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    if (observed === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic resetCheck(input int k);
    checkOutput("reset_outputs",
                {8'd0, err_of(k), busy_s[k], done_s[k], pass_s[k], ffv_s[k],
                 ffvec_s[k], ffmask_s[k], a_s[k], b_s[k]}, 32'd0);
  endtask

  // One complete run on instance k; optionally pulses start again while busy.
  task automatic applyStimulus(input int k, input bit stray_start);
    int         s;
    int         e;
    int         n;
    int         busy_cnt;
    int         ab_bad;
    int         stray_edge;
    int         exp_err;
    logic       exp_fv;
    logic [1:0] exp_vec;
    logic [6:0] exp_mask;
    s = settle_of(k);
    e = 4 * passes_of(k) * (s + 1) + 1;
    model(k, exp_err, exp_fv, exp_vec, exp_mask);
    stray_edge = stray_start ? $urandom_range(2, e - 2) : 0;

    start_s[k] = 1'b1;
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    n = 1;
    checkOutput("done_cleared", {31'd0, done_s[k]}, 32'd0);
    checkOutput("err_cleared", {24'd0, err_of(k)}, 32'd0);

    busy_cnt = 0;
    ab_bad   = 0;
    while (!done_s[k] && n < e + 20) begin
      if (busy_s[k]) busy_cnt++;
      if ({a_s[k], b_s[k]} != 2'(((n - 1) / (s + 1)) % 4)) ab_bad++;
      start_s[k] = (n == stray_edge);
      @(posedge clk); #1;
      n++;
    end
    start_s[k] = 1'b0;

    checkOutput("done_edge", n, e);
    checkOutput("busy_cycles", busy_cnt, e - 1);
    checkOutput("ab_sequence", ab_bad, 0);
    checkOutput("idle_outputs", {30'd0, busy_s[k], a_s[k] | b_s[k]}, 32'd0);
    checkOutput("err_count", {24'd0, err_of(k)}, exp_err);
    checkOutput("pass", {31'd0, pass_s[k]}, {31'd0, exp_err == 0});
    checkOutput("first_fail_valid", {31'd0, ffv_s[k]}, {31'd0, exp_fv});
    checkOutput("first_fail_vec", {30'd0, ffvec_s[k]}, {30'd0, exp_vec});
    checkOutput("first_fail_mask", {25'd0, ffmask_s[k]}, {25'd0, exp_mask});
  endtask

  task automatic clearFaults(input int k);
    for (int g = 0; g < 7; g++) fmode[k][g] = 2'd0;
  endtask

  initial begin
    int k;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      clearFaults(i);
    end

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) resetCheck(i);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] healthy gates, default configuration");
    applyStimulus(0, 1'b1);

    $display("[TB] xor stuck at 0");
    fmode[0][4] = 2'd1;
    applyStimulus(0, 1'b0);

    $display("[TB] restart from DONE with healthy gates");
    clearFaults(0);
    applyStimulus(0, 1'b0);

    $display("[TB] nand stuck at 1, three passes");
    fmode[1][1] = 2'd2;
    applyStimulus(1, 1'b0);

    $display("[TB] not inverted, saturating 2-bit counter");
    fmode[2][6] = 2'd3;
    applyStimulus(2, 1'b1);

    $display("[TB] reset during settle of vector 10");
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("mid_run_vec", {30'd0, a_s[0], b_s[0]}, 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    resetCheck(0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_after_reset", {30'd0, busy_s[0], done_s[0]}, 32'd0);

    $display("[TB] randomized fault runs");
    for (int it = 0; it < 10; it++) begin
      k = $urandom_range(0, 2);
      for (int g = 0; g < 7; g++) begin
        fmode[k][g] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      end
      applyStimulus(k, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
